myproject_dense_mul_sched: RTL
==============================

Name: myproject_dense_mul_sched

Overview:
- Sequences one shared `myproject_mul_8ns_11s_18_1_1` multiplier (8-bit unsigned × 11-bit signed, 18-bit product) across `N_IN` input/weight pairs.
- Accumulates the products into one dense-layer output neuron; this is the reuse-factor = `N_IN` controller.
- Fetches inputs and weights through single-port, 1-cycle-latency memory interfaces.
- Exposes the standard `ap_start`/`ap_done`/`ap_idle`/`ap_ready` block handshake and a registered result with a valid strobe.

Parameters:
- N_IN, 16, number of MAC terms per invocation (≥2)
- AW, 4, address width, `clog2(N_IN)`
- DIN_W, 8, input width (unsigned)
- W_W, 11, weight width (signed)
- PROD_W, 18, multiplier output width (signed, truncated)
- ACC_W, 22, accumulator/result width, `PROD_W + AW`

Ports:
- ap_clk  in  1  clock, rising edge
- ap_rst  in  1  reset, synchronous, active-high
- ap_start  in  1  start request
- ap_done  out  1  result complete, one-cycle pulse
- ap_idle  out  1  controller idle
- ap_ready  out  1  can accept new `ap_start` next cycle
- x_address0  out  AW  input memory address
- x_ce0  out  1  input memory enable
- x_q0  in  DIN_W  input memory data, valid one cycle after `ce`
- w_address0  out  AW  weight ROM address
- w_ce0  out  1  weight ROM enable
- w_q0  in  W_W  weight data, valid one cycle after `ce`
- mul_din0  out  DIN_W  to shared multiplier `din0`
- mul_din1  out  W_W  to shared multiplier `din1`
- mul_dout  in  PROD_W  from shared multiplier (combinational)
- res  out  ACC_W  signed accumulated result
- res_ap_vld  out  1  `res` valid strobe

Behaviour:
- Reset (`ap_rst`=1 at an `ap_clk` edge) values:
  - state=IDLE, `ap_idle`=1.
  - `ap_done`=`ap_ready`=`res_ap_vld`=0.
  - `x_ce0`=`w_ce0`=0, addresses=0, `res`=0, acc=0, idx=0.
- Reset overrides everything, including mid-RUN. Results in flight are discarded; no `ap_done` is issued.
- States:
  - IDLE: `ap_idle`=1. If `ap_start` → RUN, with acc cleared and idx=0.
  - RUN: `x_ce0`=`w_ce0`=1, `x_address0`=`w_address0`=idx, idx++. Leaves for DRAIN after the cycle with idx=`N_IN`-1.
  - DRAIN: no `ce`; accumulates the last product. Always → DONE.
  - DONE:
    - `ap_done`=`ap_ready`=`res_ap_vld`=1 for exactly this cycle; `res`=acc.
    - If `ap_start`=1 → RUN directly (back-to-back, acc cleared); else → IDLE.
- Data path:
  - `mul_din0`=`x_q0` and `mul_din1`=`w_q0`, passed through combinationally.
  - acc_en = `x_ce0` delayed by one cycle (registered).
  - On acc_en: acc ← acc + sign_extend(`mul_dout`, ACC_W).
- Timing:
  - Latency: `ap_start` sampled in IDLE at cycle c0 → RUN c1..c`N_IN` → DRAIN c`N_IN`+1 → DONE c`N_IN`+2.
  - Back-to-back throughput is `N_IN`+2 cycles.
- Arithmetic:
  - Product is the multiplier's 18-bit two's-complement wrap of the full 19-bit product; it is not corrected here.
  - ACC_W=`PROD_W`+AW guarantees no accumulator overflow: range −2^21..2^21−16 for `N_IN`=16.
  - No saturation logic.
- Output holding:
  - `res` holds its value after DONE until the next DONE or reset.
  - `res_ap_vld` is high only in DONE.
- Other boundaries:
  - `ap_start` in RUN or DRAIN is ignored; it is not queued.
  - `ap_start` deasserting mid-operation has no effect.
  - The shared multiplier is owned exclusively during RUN and DRAIN. `mul_din*` are don't-care outside acc_en cycles but are driven from `q0`, with no X-generation.

Decomposition:
- Package `myproject_dense_sched_pkg`:
  - `N_IN`, `DIN_W`, `W_W`, `PROD_W`, `ACC_W` constants.
  - State enum {IDLE, RUN, DRAIN, DONE}.
  - acc_t (signed ACC_W).
- One sub-module, `myproject_mac_acc`:
  - Inputs: clk, rst, clr, en, `PROD_W` product.
  - Output: registered `ACC_W` sum.
- The multiplier is instantiated by the parent, not inside this block.

Test Plan:
- x[i]=1, w[i]=1 for all 16, `ap_start` pulse → `ap_done` exactly 18 cycles after the start-sample cycle, `res`=16, `res_ap_vld` 1 cycle.
- x[i]=128, w[i]=−1024 → `res`=−2097152 (ACC_W minimum, no overflow); x[i]=127, w[i]=1023 → `res`=2078736.
- Wrap check: x[i]=255, w[i]=1023 → product wraps to −1279 → `res`=−20464.
- `ap_start` held high continuously with x[i]=i, w[i]=2 → `ap_done` every 18 cycles, each `res`=240, `ap_idle` never 1.
- `ap_rst` asserted during RUN at idx=5 → next cycle: `ap_idle`=1, `res`=0, `ce`=0, no `ap_done`; a subsequent start yields a correct result.
- `ap_start` pulsed during RUN and DRAIN → ignored: only one `ap_done`, then IDLE.

Source files
------------

// File: rtl/myproject_dense_sched_pkg.sv
// Shared constants and types for the reuse-factor-N_IN dense-neuron MAC scheduler.
package myproject_dense_sched_pkg;

    localparam int N_IN   = 16;
    localparam int AW     = $clog2(N_IN);
    localparam int DIN_W  = 8;
    localparam int W_W    = 11;
    localparam int PROD_W = 18;
    localparam int ACC_W  = PROD_W + AW;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [PROD_W-1:0] prod_t;

    function automatic acc_t sext_prod(input prod_t p);
        return acc_t'(p);
    endfunction

endpackage

// File: rtl/myproject_mac_acc.sv
// Accumulator for the shared multiplier's products; clear wins over enable.
module myproject_mac_acc
    import myproject_dense_sched_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  clr_i,
    input  logic  en_i,
    input  prod_t prod_i,
    output acc_t  acc_o
);

    acc_t acc_q;
    acc_t acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + sext_prod(prod_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/myproject_dense_mul_sched.sv
// Dense-layer neuron controller: streams N_IN input/weight pairs through one external
// multiplier and accumulates them, with an ap_start/ap_done block handshake.
module myproject_dense_mul_sched
    import myproject_dense_sched_pkg::*;
(
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic                     ap_start,
    output logic                     ap_done,
    output logic                     ap_idle,
    output logic                     ap_ready,
    output logic [AW-1:0]            x_address0,
    output logic                     x_ce0,
    input  logic [DIN_W-1:0]         x_q0,
    output logic [AW-1:0]            w_address0,
    output logic                     w_ce0,
    input  logic [W_W-1:0]           w_q0,
    output logic [DIN_W-1:0]         mul_din0,
    output logic [W_W-1:0]           mul_din1,
    input  logic [PROD_W-1:0]        mul_dout,
    output logic signed [ACC_W-1:0]  res,
    output logic                     res_ap_vld
);

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            acc_en_q;
    acc_t            res_q, res_d;
    acc_t            acc;
    logic            acc_clr;
    logic            ce;
    logic            done;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_clr = 1'b0;
        ce      = 1'b0;
        done    = 1'b0;
        ap_idle = 1'b0;
        case (state_q)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    acc_clr = 1'b1;
                end
            end
            RUN: begin
                ce    = 1'b1;
                idx_d = idx_q + AW'(1);
                if (idx_q == AW'(N_IN - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (ap_start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    acc_clr = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // In DONE the live accumulator is presented; afterwards the captured copy holds it.
    always_comb begin
        res_d = res_q;
        if (done) begin
            res_d = acc;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            acc_en_q <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_en_q <= ce;
            res_q    <= res_d;
        end
    end

    myproject_mac_acc u_mac_acc (
        .clk_i  (ap_clk),
        .rst_i  (ap_rst),
        .clr_i  (acc_clr),
        .en_i   (acc_en_q),
        .prod_i (prod_t'(mul_dout)),
        .acc_o  (acc)
    );

    assign x_address0 = idx_q;
    assign w_address0 = idx_q;
    assign x_ce0      = ce;
    assign w_ce0      = ce;
    assign mul_din0   = x_q0;
    assign mul_din1   = w_q0;
    assign ap_done    = done;
    assign ap_ready   = done;
    assign res_ap_vld = done;
    assign res        = res_d;

endmodule
